// File: rtl/tempsense_pkg.sv
// Shared definitions for the temperature-sense SAR responder.
// FSM state encoding, synchroniser depth and parameter limits.
package tempsense_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SAMPLE  = 2'd1,
      S_BIT     = 2'd2,
      S_DONE_ST = 2'd3
   } ts_state_e;

   localparam int TS_MIN_SETTLE  = 3;
   localparam int TS_SYNC_STAGES = 2;
   localparam int TS_MIN_BITS    = 2;
   localparam int TS_MAX_BITS    = 16;

   function automatic int ts_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tempsense_sync2.sv
// Two-flop synchroniser for the asynchronous comparator output.
// Ports: HF_CLK, NRST_sync (async active-low, clears to 0), d (async in), q (synced out).
module tempsense_sync2
   import tempsense_pkg::*;
(
   input  logic HF_CLK,
   input  logic NRST_sync,
   input  logic d,
   output logic q
);

   logic [TS_SYNC_STAGES-1:0] sr_q;

   always_ff @(posedge HF_CLK or negedge NRST_sync) begin
      if (!NRST_sync) begin
         sr_q <= '0;
      end else begin
         sr_q <= {sr_q[TS_SYNC_STAGES-2:0], d};
      end
   end

   assign q = sr_q[TS_SYNC_STAGES-1];

endmodule

// File: rtl/tempsense_sar_responder.sv
// SAR conversion responder for the temperature-sense run/DONE handshake.
// Ports: HF_CLK, NRST_sync, temp_run, COMP in; SAMPLE, DAC_CODE, DONE, RESULT, RESULT_VALID out.
module tempsense_sar_responder
   import tempsense_pkg::*;
#(
   parameter int N_BITS        = 10,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 4
)
(
   input  logic              HF_CLK,
   input  logic              NRST_sync,
   input  logic              temp_run,
   input  logic              COMP,
   output logic              SAMPLE,
   output logic [N_BITS-1:0] DAC_CODE,
   output logic              DONE,
   output logic [N_BITS-1:0] RESULT,
   output logic              RESULT_VALID
);

   localparam int CW = $clog2(ts_max(SAMPLE_CYCLES, SETTLE_CYCLES) + 1);
   localparam int IW = $clog2(N_BITS);

   localparam logic [CW-1:0]     SAMP_LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0]     SETL_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [IW-1:0]     IDX_TOP   = IW'(N_BITS - 1);
   localparam logic [N_BITS-1:0] CODE_MSB  = {1'b1, {(N_BITS-1){1'b0}}};

   generate
      if (SETTLE_CYCLES < TS_MIN_SETTLE) begin : g_bad_settle
         $error("SETTLE_CYCLES must be >= 3");
      end
      if (SAMPLE_CYCLES < 1) begin : g_bad_sample
         $error("SAMPLE_CYCLES must be >= 1");
      end
      if (N_BITS < TS_MIN_BITS || N_BITS > TS_MAX_BITS) begin : g_bad_bits
         $error("N_BITS must be in 2..16");
      end
   endgenerate

   ts_state_e         state_q;
   logic [CW-1:0]     cnt_q;
   logic [IW-1:0]     idx_q;
   logic              comp_s;
   logic [N_BITS-1:0] trial_code;

   tempsense_sync2 u_comp_sync (
      .HF_CLK    (HF_CLK),
      .NRST_sync (NRST_sync),
      .d         (COMP),
      .q         (comp_s)
   );

   // Decide the current bit and pre-set the next lower one.
   always_comb begin
      trial_code = DAC_CODE;
      if (!comp_s) begin
         trial_code[idx_q] = 1'b0;
      end
      if (idx_q != '0) begin
         trial_code[idx_q - 1'b1] = 1'b1;
      end
   end

   always_ff @(posedge HF_CLK or negedge NRST_sync) begin
      if (!NRST_sync) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= IDX_TOP;
         SAMPLE       <= 1'b0;
         DAC_CODE     <= '0;
         DONE         <= 1'b0;
         RESULT       <= '0;
         RESULT_VALID <= 1'b0;
      end else begin
         RESULT_VALID <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               SAMPLE   <= 1'b0;
               DONE     <= 1'b0;
               DAC_CODE <= '0;
               cnt_q    <= '0;
               idx_q    <= IDX_TOP;
               if (temp_run) begin
                  state_q <= S_SAMPLE;
                  SAMPLE  <= 1'b1;
               end
            end
            S_SAMPLE: begin
               if (!temp_run) begin
                  state_q  <= S_IDLE;
                  SAMPLE   <= 1'b0;
                  DAC_CODE <= '0;
                  cnt_q    <= '0;
               end else if (cnt_q == SAMP_LAST) begin
                  state_q  <= S_BIT;
                  SAMPLE   <= 1'b0;
                  DAC_CODE <= CODE_MSB;
                  idx_q    <= IDX_TOP;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_BIT: begin
               if (!temp_run) begin
                  state_q  <= S_IDLE;
                  DAC_CODE <= '0;
                  cnt_q    <= '0;
                  idx_q    <= IDX_TOP;
               end else if (cnt_q == SETL_LAST) begin
                  DAC_CODE <= trial_code;
                  cnt_q    <= '0;
                  if (idx_q == '0) begin
                     state_q      <= S_DONE_ST;
                     RESULT       <= trial_code;
                     RESULT_VALID <= 1'b1;
                  end else begin
                     idx_q <= idx_q - 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE_ST: begin
               // DONE is a level held until the controller drops run.
               if (!temp_run) begin
                  state_q  <= S_IDLE;
                  DONE     <= 1'b0;
                  DAC_CODE <= '0;
                  idx_q    <= IDX_TOP;
               end else begin
                  DONE <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tempsense_sar_responder.sv
// Directed bench for tempsense_sar_responder (N_BITS=4, SAMPLE=2, SETTLE=3).
// Ideal comparator: COMP = (vin >= DAC_CODE).
module tb_tempsense_sar_responder;

   logic       HF_CLK = 1'b0;
   logic       NRST_sync;
   logic       temp_run;
   logic       COMP;
   logic       SAMPLE;
   logic [3:0] DAC_CODE;
   logic       DONE;
   logic [3:0] RESULT;
   logic       RESULT_VALID;
   logic [3:0] vin;

   int tests  = 0;
   int failed = 0;
   logic [3:0] dac_q[$];

   typedef struct {
      logic [3:0] v;
      logic [3:0] res;
      int         dcyc;
   } vec_t;

   vec_t vecs[6];

   always #5 HF_CLK = ~HF_CLK;

   assign COMP = (vin >= DAC_CODE);

   tempsense_sar_responder #(
      .N_BITS        (4),
      .SAMPLE_CYCLES (2),
      .SETTLE_CYCLES (3)
   ) dut (
      .HF_CLK       (HF_CLK),
      .NRST_sync    (NRST_sync),
      .temp_run     (temp_run),
      .COMP         (COMP),
      .SAMPLE       (SAMPLE),
      .DAC_CODE     (DAC_CODE),
      .DONE         (DONE),
      .RESULT       (RESULT),
      .RESULT_VALID (RESULT_VALID)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Starts a conversion at the current negedge; cycle 0 = first posedge.
   task automatic run_conv(input logic [3:0] v, output int done_cyc,
                           output int samp_n, output int rv_n);
      logic [3:0] prev;
      vin      = v;
      temp_run = 1'b1;
      done_cyc = -1;
      samp_n   = 0;
      rv_n     = 0;
      dac_q.delete();
      prev = DAC_CODE;
      for (int c = 0; c < 40 && done_cyc < 0; c++) begin
         @(posedge HF_CLK);
         @(negedge HF_CLK);
         if (SAMPLE) samp_n++;
         if (RESULT_VALID) rv_n++;
         if (DAC_CODE != prev) begin
            dac_q.push_back(DAC_CODE);
            prev = DAC_CODE;
         end
         if (DONE) done_cyc = c;
      end
   endtask

   initial begin
      int dc, sn, rn, bad;
      vecs[0] = '{4'd11, 4'hB, 15};
      vecs[1] = '{4'd15, 4'hF, 15};
      vecs[2] = '{4'd0,  4'h0, 15};
      vecs[3] = '{4'd6,  4'h6, 15};
      vecs[4] = '{4'd3,  4'h3, 15};
      vecs[5] = '{4'd8,  4'h8, 15};

      NRST_sync = 1'b0;
      temp_run  = 1'b0;
      vin       = 4'd0;
      #12;
      chk("rst_sample", int'(SAMPLE), 0);
      chk("rst_dac", int'(DAC_CODE), 0);
      chk("rst_done", int'(DONE), 0);
      chk("rst_result", int'(RESULT), 0);
      chk("rst_rv", int'(RESULT_VALID), 0);
      @(negedge HF_CLK);
      NRST_sync = 1'b1;
      @(negedge HF_CLK);

      for (int i = 0; i < 6; i++) begin
         run_conv(vecs[i].v, dc, sn, rn);
         chk($sformatf("v%0d_done_cyc", i), dc, vecs[i].dcyc);
         chk($sformatf("v%0d_result", i), int'(RESULT), int'(vecs[i].res));
         chk($sformatf("v%0d_sample_n", i), sn, 2);
         chk($sformatf("v%0d_rv_n", i), rn, 1);
         temp_run = 1'b0;
         @(posedge HF_CLK);
         @(negedge HF_CLK);
         chk($sformatf("v%0d_done_drop", i), int'(DONE), 0);
      end

      run_conv(4'd0, dc, sn, rn);
      chk("v0_seq_len", dac_q.size(), 5);
      if (dac_q.size() == 5) begin
         chk("v0_seq0", int'(dac_q[0]), 8);
         chk("v0_seq1", int'(dac_q[1]), 4);
         chk("v0_seq2", int'(dac_q[2]), 2);
         chk("v0_seq3", int'(dac_q[3]), 1);
         chk("v0_seq4", int'(dac_q[4]), 0);
      end
      temp_run = 1'b0;
      @(negedge HF_CLK);

      run_conv(4'd5, dc, sn, rn);
      chk("hold_done_cyc", dc, 15);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge HF_CLK);
         if (!DONE || SAMPLE || RESULT_VALID || DAC_CODE != 4'd5) bad++;
      end
      chk("hold_bad_cycles", bad, 0);
      temp_run = 1'b0;
      @(posedge HF_CLK);
      @(negedge HF_CLK);
      chk("hold_done_drop", int'(DONE), 0);

      vin      = 4'd9;
      temp_run = 1'b1;
      repeat (7) @(posedge HF_CLK);
      @(negedge HF_CLK);
      chk("abort_in_bit", int'(DAC_CODE != 4'd0), 1);
      temp_run = 1'b0;
      @(posedge HF_CLK);
      @(negedge HF_CLK);
      chk("abort_dac_idle", int'(DAC_CODE), 0);
      chk("abort_sample", int'(SAMPLE), 0);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge HF_CLK);
         if (DONE || RESULT_VALID) bad++;
      end
      chk("abort_no_done_rv", bad, 0);
      chk("abort_result_kept", int'(RESULT), 5);

      vin      = 4'd12;
      temp_run = 1'b1;
      repeat (6) @(posedge HF_CLK);
      #2;
      NRST_sync = 1'b0;
      #1;
      chk("arst_dac", int'(DAC_CODE), 0);
      chk("arst_sample", int'(SAMPLE), 0);
      chk("arst_done", int'(DONE), 0);
      chk("arst_result", int'(RESULT), 0);
      chk("arst_rv", int'(RESULT_VALID), 0);
      temp_run = 1'b0;
      @(negedge HF_CLK);
      NRST_sync = 1'b1;
      @(negedge HF_CLK);
      run_conv(4'd6, dc, sn, rn);
      chk("post_rst_result", int'(RESULT), 6);
      chk("post_rst_done_cyc", dc, 15);

      temp_run = 1'b0;
      @(negedge HF_CLK);
      chk("b2b_gap_done", int'(DONE), 0);
      run_conv(4'd10, dc, sn, rn);
      chk("b2b_done_cyc", dc, 15);
      chk("b2b_result", int'(RESULT), 10);
      temp_run = 1'b0;
      @(negedge HF_CLK);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
